// File: rtl/sram_sample_writer_if.sv
// Sample-in and playback-read handshake between the recorder/player and the SRAM writer.
interface sram_sample_writer_if;
    logic        i_wr_valid;
    logic [19:0] i_wr_addr;
    logic [15:0] i_wr_data;
    logic        i_rd_req;
    logic [19:0] i_rd_addr;
    logic        o_rd_ready;
    logic        o_rd_valid;
    logic [15:0] o_rd_data;

    modport master (
        output i_wr_valid, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
        input  o_rd_ready, o_rd_valid, o_rd_data
    );

    modport slave (
        input  i_wr_valid, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
        output o_rd_ready, o_rd_valid, o_rd_data
    );
endinterface

// File: rtl/sram_sample_writer.sv
// Buffers audio samples in a small FIFO and performs timed writes to a 1Mx16 async SRAM,
// sharing the port with single-word playback reads whenever no write is queued.
//
// state   | meaning
// S_IDLE  | strobes high, dq released; pop a queued sample or start a pending read
// S_WRITE | WE_N/CE_N low for WR_CYCLES clocks, dq driven with the sample
// S_READ  | OE_N/CE_N low for RD_CYCLES clocks, dq captured on the last one
module sram_sample_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int WR_CYCLES  = 2,
    parameter int RD_CYCLES  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    sram_sample_writer_if.slave  smp,
    output logic [19:0]          o_end_addr,
    output logic                 o_overflow,
    output logic [19:0]          o_sram_addr,
    inout  wire  [15:0]          io_sram_dq,
    output logic                 o_sram_we_n,
    output logic                 o_sram_oe_n,
    output logic                 o_sram_ce_n,
    output logic                 o_sram_lb_n,
    output logic                 o_sram_ub_n
);
    localparam int MAX_CYC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] WR_LAST  = CW'(WR_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'(RD_CYCLES - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [15:0]     wr_data_r;
    logic [19:0]     rd_addr_r;
    logic            rd_pending;
    logic            dq_oe;

    logic [35:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic [35:0]     head;
    logic            pop;
    logic            push;

    assign head = fifo_mem[rd_ptr];
    assign pop  = (state == S_IDLE) && (count != '0);
    // A full FIFO still accepts a sample in the cycle its head is popped.
    assign push = smp.i_wr_valid && ((count != FULL_CNT) || pop);

    assign io_sram_dq     = dq_oe ? wr_data_r : 16'hzzzz;
    assign o_sram_lb_n    = 1'b0;
    assign o_sram_ub_n    = 1'b0;
    assign smp.o_rd_ready = ~rd_pending;

    always_ff @(posedge i_clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {smp.i_wr_addr, smp.i_wr_data};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (smp.i_wr_valid && !push)
                o_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            wr_data_r      <= '0;
            rd_addr_r      <= '0;
            rd_pending     <= 1'b0;
            dq_oe          <= 1'b0;
            o_sram_addr    <= '0;
            o_sram_we_n    <= 1'b1;
            o_sram_oe_n    <= 1'b1;
            o_sram_ce_n    <= 1'b1;
            smp.o_rd_valid <= 1'b0;
            smp.o_rd_data  <= '0;
            o_end_addr     <= '0;
        end else begin
            smp.o_rd_valid <= 1'b0;
            if (smp.i_rd_req && !rd_pending) begin
                rd_pending <= 1'b1;
                rd_addr_r  <= smp.i_rd_addr;
            end
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        o_sram_addr <= head[35:16];
                        wr_data_r   <= head[15:0];
                        cnt         <= '0;
                        o_sram_ce_n <= 1'b0;
                        o_sram_we_n <= 1'b0;
                        dq_oe       <= 1'b1;
                        state       <= S_WRITE;
                    end else if (rd_pending) begin
                        o_sram_addr <= rd_addr_r;
                        cnt         <= '0;
                        o_sram_ce_n <= 1'b0;
                        o_sram_oe_n <= 1'b0;
                        state       <= S_READ;
                    end
                end
                S_WRITE: begin
                    if (cnt == WR_LAST) begin
                        o_sram_ce_n <= 1'b1;
                        o_sram_we_n <= 1'b1;
                        dq_oe       <= 1'b0;
                        o_end_addr  <= o_sram_addr;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_READ: begin
                    if (cnt == RD_LAST) begin
                        o_sram_ce_n    <= 1'b1;
                        o_sram_oe_n    <= 1'b1;
                        smp.o_rd_data  <= io_sram_dq;
                        smp.o_rd_valid <= 1'b1;
                        rd_pending     <= 1'b0;
                        state          <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_sample_writer.sv
// Randomised and directed checks of sram_sample_writer against a timeline model of the SRAM port.
module tb_sram_sample_writer;
    localparam int DEPTH = 4;
    localparam int WRC   = 2;
    localparam int RDC   = 2;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [19:0] end_addr, sram_addr;
    logic        overflow, we_n, oe_n, ce_n, lb_n, ub_n;
    wire  [15:0] sram_dq;

    always #5 i_clk = ~i_clk;

    sram_sample_writer_if smp ();

    sram_sample_writer #(.FIFO_DEPTH(DEPTH), .WR_CYCLES(WRC), .RD_CYCLES(RDC)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .smp         (smp),
        .o_end_addr  (end_addr),
        .o_overflow  (overflow),
        .o_sram_addr (sram_addr),
        .io_sram_dq  (sram_dq),
        .o_sram_we_n (we_n),
        .o_sram_oe_n (oe_n),
        .o_sram_ce_n (ce_n),
        .o_sram_lb_n (lb_n),
        .o_sram_ub_n (ub_n)
    );

    // external SRAM
    bit   [15:0] sram [0:1048575];
    logic        pre_en = 1'b0;
    logic [19:0] pre_addr = '0;
    logic [15:0] pre_data = '0;
    assign sram_dq = (!oe_n && !ce_n) ? sram[sram_addr] : 16'hzzzz;
    always @(posedge i_clk) begin
        if (pre_en)
            sram[pre_addr] <= pre_data;
        else if (!we_n && !ce_n)
            sram[sram_addr] <= sram_dq;
    end

    // reference model: sample queue plus the time window of the current SRAM access
    typedef struct packed {logic [19:0] a; logic [15:0] d;} smp_t;
    smp_t        q[$];
    logic [15:0] ref_mem [bit [19:0]];
    int          c;
    int          act_kind;  // 0 none, 1 write, 2 read
    int          act_from, act_end;
    logic [19:0] act_addr;
    logic [15:0] act_data;
    logic        pend;
    logic [19:0] pend_addr;
    logic [19:0] e_end_addr, e_sram_addr;
    logic [15:0] e_rd_data;
    logic        e_ovf, e_ovf_nxt;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, c, got, want);
        end
    endtask

    task model_reset();
        q.delete();
        act_kind    = 0;
        act_end     = -1;
        act_from    = 0;
        pend        = 1'b0;
        e_end_addr  = '0;
        e_sram_addr = '0;
        e_rd_data   = '0;
        e_ovf_nxt   = 1'b0;
    endtask

    task cyc(input logic rst, input logic wv, input logic [19:0] wa, input logic [15:0] wd,
             input logic rr, input logic [19:0] ra);
        logic in_act, e_rv, idle, popped;
        int   pre;
        smp_t s;
        e_rv = 1'b0;
        if (act_kind == 1 && c == act_end + 1) e_end_addr = act_addr;
        if (act_kind == 2 && c == act_end + 1) begin
            e_rv      = 1'b1;
            e_rd_data = act_data;
            pend      = 1'b0;
        end
        e_ovf  = e_ovf_nxt;
        in_act = (act_kind != 0) && (c >= act_from) && (c <= act_end);
        chk("strobes", {ce_n, we_n, oe_n},
            {!in_act, !(in_act && act_kind == 1), !(in_act && act_kind == 2)});
        chk("sram_addr", sram_addr, e_sram_addr);
        if (in_act && act_kind == 1) chk("dq", sram_dq, act_data);
        chk("rd_valid", smp.o_rd_valid, e_rv);
        chk("rd_data", smp.o_rd_data, e_rd_data);
        chk("rd_ready", smp.o_rd_ready, !pend);
        chk("end_addr", end_addr, e_end_addr);
        chk("overflow", overflow, e_ovf);
        chk("byte_en", {lb_n, ub_n}, 2'b00);

        i_rst          = rst;
        smp.i_wr_valid = wv;
        smp.i_wr_addr  = wa;
        smp.i_wr_data  = wd;
        smp.i_rd_req   = rr;
        smp.i_rd_addr  = ra;

        if (rst) begin
            model_reset();
        end else begin
            pre    = q.size();
            idle   = (act_kind == 0) || (c > act_end);
            popped = 1'b0;
            if (idle && pre > 0) begin
                s           = q.pop_front();
                act_kind    = 1;
                act_from    = c + 1;
                act_end     = c + WRC;
                act_addr    = s.a;
                act_data    = s.d;
                ref_mem[s.a] = s.d;
                e_sram_addr = s.a;
                popped      = 1'b1;
            end else if (idle && pend) begin
                act_kind    = 2;
                act_from    = c + 1;
                act_end     = c + RDC;
                act_addr    = pend_addr;
                act_data    = ref_mem.exists(pend_addr) ? ref_mem[pend_addr] : 16'h0;
                e_sram_addr = pend_addr;
            end
            if (wv) begin
                if (pre < DEPTH || popped) q.push_back('{a: wa, d: wd});
                else e_ovf_nxt = 1'b1;
            end
            if (rr && !pend) begin
                pend      = 1'b1;
                pend_addr = ra;
            end
        end
        @(negedge i_clk);
        c++;
    endtask

    task idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task preload(input logic [19:0] a, input logic [15:0] d);
        pre_addr   = a;
        pre_data   = d;
        pre_en     = 1'b1;
        ref_mem[a] = d;
        idle_n(1);
        pre_en     = 1'b0;
    endtask

    initial begin
        i_rst          = 1'b1;
        smp.i_wr_valid = 1'b0;
        smp.i_wr_addr  = '0;
        smp.i_wr_data  = '0;
        smp.i_rd_req   = 1'b0;
        smp.i_rd_addr  = '0;
        c              = 0;
        model_reset();
        repeat (2) @(negedge i_clk);

        // single write
        cyc(1'b0, 1'b1, 20'h00005, 16'hA5A5, 1'b0, '0);
        idle_n(6);

        // bursts of 6 and 8 back-to-back strobes
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 20'h00100 + 20'(i), 16'(16'h1100 + i), 1'b0, '0);
        idle_n(20);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 20'h00200 + 20'(i), 16'(16'h2200 + i), 1'b0, '0);
        idle_n(30);
        chk("overflow_sticky", overflow, 1'b1);

        // read of a preloaded word
        preload(20'h00010, 16'h1234);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 20'h00010);
        idle_n(8);

        // writes queued while a read is pending go first; a second request is ignored
        cyc(1'b0, 1'b1, 20'h00020, 16'hBEEF, 1'b1, 20'h00010);
        cyc(1'b0, 1'b1, 20'h00010, 16'hCAFE, 1'b0, '0);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 20'h00055);
        idle_n(12);

        // address wrap at max sustained rate
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, 20'hFFFFE + 20'(i), 16'(16'h3000 + i), 1'b0, '0);
            idle_n(WRC);
        end
        idle_n(8);

        // reset in the middle of a write
        cyc(1'b0, 1'b1, 20'h00777, 16'h7777, 1'b0, '0);
        cyc(1'b0, 1'b1, 20'h00778, 16'h7778, 1'b1, 20'h00005);
        cyc(1'b0, 1'b0, '0, '0, 1'b0, '0);
        cyc(1'b1, 1'b0, '0, '0, 1'b0, '0);
        idle_n(6);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(499) == 0),
                ($urandom_range(99) < 40), 20'($urandom_range(63)), 16'($urandom),
                ($urandom_range(99) < 15), 20'($urandom_range(63)));
        end
        idle_n(40);

        foreach (ref_mem[k]) chk("sram_contents", sram[k], ref_mem[k]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
